// File: rtl/hub75_pkg.sv
// HUB75 capture shared definitions: geometry defaults, channel/colour bit indices, capture state.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hub75_pkg;

    localparam int HUB75_COLS     = 32;
    localparam int HUB75_ROW_BITS = 4;
    localparam int HUB75_COL_BITS = $clog2(HUB75_COLS);

    // {bank, row, col}
    localparam int PIX_ADDR_W = 1 + HUB75_ROW_BITS + HUB75_COL_BITS;

    // Bit positions inside the 3-bit {B,G,R} pixel word.
    localparam int RGB_R = 0;
    localparam int RGB_G = 1;
    localparam int RGB_B = 2;

    // Serial channel indices: bank 0 = R0/G0/B0, bank 1 = R1/G1/B1.
    localparam int HUB75_NCH = 6;
    localparam int CH_R0 = 0;
    localparam int CH_G0 = 1;
    localparam int CH_B0 = 2;
    localparam int CH_R1 = 3;
    localparam int CH_G1 = 4;
    localparam int CH_B1 = 5;

    typedef enum logic {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } cap_state_e;

endpackage

// File: rtl/hub75_capture_if.sv
// Pixel word stream leaving the HUB75 capture block (valid/ready).
// Latency: n/a (wires only).
// Backpressure: master holds PIX_ADDR/PIX_RGB while PIX_VALID & !PIX_READY.
// Signals: PIX_VALID, PIX_READY, PIX_ADDR {bank,row,col}, PIX_RGB {B,G,R}.
interface hub75_capture_if #(
    parameter int ADDR_W = hub75_pkg::PIX_ADDR_W
);
    logic              PIX_VALID;
    logic              PIX_READY;
    logic [ADDR_W-1:0] PIX_ADDR;
    logic [2:0]        PIX_RGB;

    modport master (
        output PIX_VALID,
        output PIX_ADDR,
        output PIX_RGB,
        input  PIX_READY
    );

    modport slave (
        input  PIX_VALID,
        input  PIX_ADDR,
        input  PIX_RGB,
        output PIX_READY
    );
endinterface

// File: rtl/hub75_sync_edge.sv
// Multi-flop synchronizer for a bundle of async lines, with rising-edge pulses on the low EDGE_W lines.
// Latency: STAGES cycles for levels and pulses alike, so every line stays aligned.
// Backpressure: none.
// Ports: clk_i, rst_i (sync, active-high), d_i (raw lines), lvl_o (synced upper lines), rise_o (edge pulses).
module hub75_sync_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 4,
    parameter int EDGE_W = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WIDTH-1:0]        d_i,
    output logic [WIDTH-EDGE_W-1:0] lvl_o,
    output logic [EDGE_W-1:0]       rise_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [EDGE_W-1:0]            prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1][EDGE_W-1:0];
        end
    end

    assign rise_o = sync_q[STAGES-1][EDGE_W-1:0] & ~prev_q;
    assign lvl_o  = sync_q[STAGES-1][WIDTH-1:EDGE_W];

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receiver: oversamples the panel bus, rebuilds each latched row and streams it as {bank,row,col} pixel words.
// Latency: PIX_VALID rises the cycle after the synced LATCH edge (SYNC_STAGES+1 cycles after the raw edge); one word per accepted cycle.
// Backpressure: words advance only on PIX_VALID & PIX_READY; a latch arriving mid-drain is dropped and flagged in OVERFLOW.
// Ports: CLK_I, RST_I (sync, active-high); HUB_R0/G0/B0/R1/G1/B1, HUB_CLK, HUB_LATCH, HUB_ADDR;
//        pix (master: PIX_VALID/PIX_READY/PIX_ADDR/PIX_RGB); ROW_DONE pulse; OVERFLOW, LEN_ERR sticky.
// Optional: HUB75_CAPTURE_STATS_EN adds wrapping 16-bit LATCH_CNT and FRAME_CNT outputs.
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int COLS        = HUB75_COLS,
    parameter int ROW_BITS    = HUB75_ROW_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                HUB_R0,
    input  logic                HUB_G0,
    input  logic                HUB_B0,
    input  logic                HUB_R1,
    input  logic                HUB_G1,
    input  logic                HUB_B1,
    input  logic                HUB_CLK,
    input  logic                HUB_LATCH,
    input  logic [ROW_BITS-1:0] HUB_ADDR,
    hub75_capture_if.master     pix,
    output logic                ROW_DONE,
    output logic                OVERFLOW,
    output logic                LEN_ERR
`ifdef HUB75_CAPTURE_STATS_EN
    ,
    output logic [15:0]         LATCH_CNT,
    output logic [15:0]         FRAME_CNT
`endif
);

    localparam int COL_BITS = $clog2(COLS);
    localparam int IDX_W    = COL_BITS + 1;          // {bank, col}
    localparam int CNT_W    = $clog2(COLS + 2);      // must hold COLS+1
    localparam int NCH      = HUB75_NCH;
    localparam int DW       = NCH + ROW_BITS;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COLS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * COLS - 1);

    // ---------------------------------------------------------------
    // Input synchronization. Strobes and data share one chain so the
    // data sampled with a CLK edge is exactly what the driver presented.
    // ---------------------------------------------------------------
    logic [DW-1:0]       lvl;
    logic [1:0]          rise;
    logic                clk_rise;
    logic                latch_rise;
    logic [NCH-1:0]      dat_s;
    logic [ROW_BITS-1:0] addr_s;

    hub75_sync_edge #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (DW + 2),
        .EDGE_W (2)
    ) u_sync (
        .clk_i  (CLK_I),
        .rst_i  (RST_I),
        .d_i    ({HUB_ADDR, HUB_B1, HUB_G1, HUB_R1, HUB_B0, HUB_G0, HUB_R0, HUB_LATCH, HUB_CLK}),
        .lvl_o  (lvl),
        .rise_o (rise)
    );

    assign clk_rise   = rise[0];
    assign latch_rise = rise[1];
    assign dat_s      = lvl[NCH-1:0];
    assign addr_s     = lvl[DW-1:NCH];

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    cap_state_e                    state_q;
    logic [NCH-1:0][COLS-1:0]      sr_q;
    logic [NCH-1:0][COLS-1:0]      sr_d;
    logic [NCH-1:0][COLS-1:0]      hold_q;
    logic [ROW_BITS-1:0]           row_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [CNT_W-1:0]              cnt_d;
    logic                          len_bad;
    logic [IDX_W-1:0]              idx_q;
    logic [IDX_W-1:0]              idx_d;
    logic                          valid_q;
    logic [1+ROW_BITS+COL_BITS-1:0] addr_q;
    logic [2:0]                    rgb_q;
    logic                          row_done_q;
    logic                          ovf_q;
    logic                          len_q;
`ifdef HUB75_CAPTURE_STATS_EN
    logic [15:0]                   latch_cnt_q;
    logic [15:0]                   frame_cnt_q;
    logic [ROW_BITS-1:0]           prev_row_q;
`endif

    // {B,G,R} of one pixel from a row image, idx = {bank, col}.
    function automatic logic [2:0] pick(input logic [NCH-1:0][COLS-1:0] h,
                                        input logic [IDX_W-1:0]         idx);
        logic [COL_BITS-1:0] col;
        logic [2:0]          rgb;
        col = idx[COL_BITS-1:0];
        if (idx[COL_BITS]) begin
            rgb[RGB_R] = h[CH_R1][col];
            rgb[RGB_G] = h[CH_G1][col];
            rgb[RGB_B] = h[CH_B1][col];
        end else begin
            rgb[RGB_R] = h[CH_R0][col];
            rgb[RGB_G] = h[CH_G0][col];
            rgb[RGB_B] = h[CH_B0][col];
        end
        return rgb;
    endfunction

    // Shift happens before the latch looks at the registers, so a CLK
    // edge coinciding with LATCH is included in both the data and the count.
    always_comb begin
        sr_d = sr_q;
        if (clk_rise) begin
            for (int ch = 0; ch < NCH; ch++) begin
                sr_d[ch] = {dat_s[ch], sr_q[ch][COLS-1:1]};
            end
        end

        cnt_d = cnt_q;
        if (clk_rise && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        len_bad = latch_rise && (cnt_d != CNT_FULL);
        if (latch_rise) begin
            cnt_d = '0;
        end

        idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= CAPTURE;
            sr_q       <= '0;
            hold_q     <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            rgb_q      <= '0;
            row_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            len_q      <= 1'b0;
`ifdef HUB75_CAPTURE_STATS_EN
            latch_cnt_q <= '0;
            frame_cnt_q <= '0;
            prev_row_q  <= '0;
`endif
        end else begin
            // Capture never pauses, even while the held row drains.
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            row_done_q <= 1'b0;
            if (len_bad) begin
                len_q <= 1'b1;
            end

            case (state_q)
                CAPTURE: begin
                    if (latch_rise) begin
                        hold_q  <= sr_d;
                        row_q   <= addr_s;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        addr_q  <= {1'b0, addr_s, {COL_BITS{1'b0}}};
                        rgb_q   <= pick(sr_d, '0);
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A latch here is dropped; the held row keeps draining.
                    if (latch_rise) begin
                        ovf_q <= 1'b1;
                    end
                    if (valid_q && pix.PIX_READY) begin
                        if (idx_q == IDX_LAST) begin
                            valid_q    <= 1'b0;
                            row_done_q <= 1'b1;
                            state_q    <= CAPTURE;
                        end else begin
                            idx_q  <= idx_d;
                            addr_q <= {idx_d[COL_BITS], row_q, idx_d[COL_BITS-1:0]};
                            rgb_q  <= pick(hold_q, idx_d);
                        end
                    end
                end
                default: state_q <= CAPTURE;
            endcase

`ifdef HUB75_CAPTURE_STATS_EN
            if (latch_rise) begin
                latch_cnt_q <= latch_cnt_q + 16'd1;
            end
            // Frame boundary: accepted row 0 directly after an accepted last row.
            if (latch_rise && (state_q == CAPTURE)) begin
                if ((addr_s == '0) && (prev_row_q == '1)) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
                prev_row_q <= addr_s;
            end
`endif
        end
    end

    assign pix.PIX_VALID = valid_q;
    assign pix.PIX_ADDR  = addr_q;
    assign pix.PIX_RGB   = rgb_q;
    assign ROW_DONE      = row_done_q;
    assign OVERFLOW      = ovf_q;
    assign LEN_ERR       = len_q;
`ifdef HUB75_CAPTURE_STATS_EN
    assign LATCH_CNT     = latch_cnt_q;
    assign FRAME_CNT     = frame_cnt_q;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Testbench for hub75_capture: table of rows driven over the HUB75 bus, scoreboard of expected pixel words.
// Latency: n/a.
// Backpressure: PIX_READY driven always-high or 1-of-3 cycles.
module tb_hub75_capture;
    import hub75_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0 = 1'b0, g0 = 1'b0, b0 = 1'b0, r1 = 1'b0, g1 = 1'b0, b1 = 1'b0;
    logic        hclk = 1'b0, hlat = 1'b0;
    logic [3:0]  haddr = 4'h0;
    logic        row_done, overflow, len_err;
`ifdef HUB75_CAPTURE_STATS_EN
    logic [15:0] latch_cnt, frame_cnt;
`endif

    hub75_capture_if pif ();

    hub75_capture dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .HUB_R0    (r0),
        .HUB_G0    (g0),
        .HUB_B0    (b0),
        .HUB_R1    (r1),
        .HUB_G1    (g1),
        .HUB_B1    (b1),
        .HUB_CLK   (hclk),
        .HUB_LATCH (hlat),
        .HUB_ADDR  (haddr),
        .pix       (pif),
        .ROW_DONE  (row_done),
        .OVERFLOW  (overflow),
        .LEN_ERR   (len_err)
`ifdef HUB75_CAPTURE_STATS_EN
        ,
        .LATCH_CNT (latch_cnt),
        .FRAME_CNT (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] addr;
        logic [2:0] rgb;
    } word_t;
    word_t exp_q[$];

    typedef struct {
        int          nclk;
        logic [31:0] r0, g0, b0, r1, g1, b1;
        logic [3:0]  addr;
        bit          slow_ready;
        int          relatch_gap;   // 0 = none; else cycles after the latch pulse before a second latch
        bit          reset_first;
        bit          exp_ovf;
        bit          exp_len;
    } vec_t;

    logic [31:0] m_sr [6];          // reference shift registers, index = channel
    int          acc_cnt  = 0;
    int          done_cnt = 0;
    bit          slow_ready = 1'b0;
    int          rcyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sink: ready always, or one cycle in three.
    initial begin
        pif.PIX_READY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            pif.PIX_READY = !slow_ready || (rcyc % 3 == 0);
        end
    end

    // Scoreboard: every valid cycle must present the head of the queue (so a
    // stalled word must hold), and a word is retired only when accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pif.PIX_VALID) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=0x%0h expected=none", {pif.PIX_ADDR, pif.PIX_RGB});
                    end else begin
                        chk("word", 32'({pif.PIX_ADDR, pif.PIX_RGB}), 32'({exp_q[0].addr, exp_q[0].rgb}));
                        if (pif.PIX_READY) begin
                            void'(exp_q.pop_front());
                            acc_cnt++;
                        end
                    end
                end
                if (row_done) done_cnt++;
            end
        end
    end

    task automatic hub_bit(input logic [5:0] d);
        {b1, g1, r1, b0, g0, r0} = d;
        hclk = 1'b0;
        cyc(2);
        hclk = 1'b1;
        cyc(2);
        hclk = 1'b0;
        for (int ch = 0; ch < 6; ch++) m_sr[ch] = {d[ch], m_sr[ch][31:1]};
    endtask

    task automatic shift_row(input vec_t v);
        for (int i = 0; i < v.nclk; i++)
            hub_bit({v.b1[i], v.g1[i], v.r1[i], v.b0[i], v.g0[i], v.r0[i]});
    endtask

    task automatic push_row();
        word_t w;
        for (int bank = 0; bank < 2; bank++) begin
            for (int col = 0; col < 32; col++) begin
                w.addr = {1'(bank), haddr, 5'(col)};
                if (bank == 1) w.rgb = {m_sr[5][col], m_sr[4][col], m_sr[3][col]};
                else           w.rgb = {m_sr[2][col], m_sr[1][col], m_sr[0][col]};
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic latch_pulse();
        hlat = 1'b1;
        cyc(2);
        hlat = 1'b0;
        cyc(2);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            cyc(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
        cyc(4);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hclk = 1'b0;
        hlat = 1'b0;
        cyc(3);
        rst = 1'b0;
        exp_q.delete();
        for (int ch = 0; ch < 6; ch++) m_sr[ch] = '0;
        cyc(2);
    endtask

    task automatic row_checks(input string tag, input int acc0, input int done0,
                              input bit exp_ovf, input bit exp_len);
        chk({tag, "_words"},    acc_cnt - acc0, 64);
        chk({tag, "_row_done"}, done_cnt - done0, 1);
        chk({tag, "_valid_idle"}, pif.PIX_VALID, 0);
        chk({tag, "_overflow"}, overflow, exp_ovf);
        chk({tag, "_len_err"},  len_err, exp_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    vec_t tbl [5];

    initial begin
        int acc0, done0;

        // Full row: single R0 bit at col 5, single B1 bit at col 31.
        tbl[0] = '{32, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 4'h3, 0, 0, 0, 0, 0};
        // Dense patterns under 1-of-3 backpressure.
        tbl[1] = '{32, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_F0F0, 32'h8000_0001, 32'h5555_AAAA,
                   4'h7, 1, 0, 0, 0, 0};
        // Short row: 31 clocks, col 0 keeps a stale bit from the previous row.
        tbl[2] = '{31, 32'h7FFF_FFFE, 32'h0000_0003, 32'h4000_0000, 32'h1111_1111, 32'h0, 32'h2222_2222,
                   4'hA, 0, 0, 0, 0, 1};
        // Proper row afterwards: drains correctly, LEN_ERR stays set.
        tbl[3] = '{32, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
                   4'hC, 0, 0, 0, 0, 1};
        // Second latch ~10 cycles into the drain: dropped. It follows zero
        // clocks, so it also trips LEN_ERR.
        tbl[4] = '{32, 32'hF0F0_F0F0, 32'h0000_FFFF, 32'h3C3C_3C3C, 32'h0000_0001, 32'h8000_0000, 32'hAAAA_5555,
                   4'h9, 0, 6, 1, 1, 1};

        for (int ch = 0; ch < 6; ch++) m_sr[ch] = '0;

        // Reset values, sampled while reset is held.
        cyc(3);
        @(negedge clk);
        chk("rst_valid",    pif.PIX_VALID, 0);
        chk("rst_addr",     32'(pif.PIX_ADDR), 0);
        chk("rst_rgb",      32'(pif.PIX_RGB), 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_len_err",  len_err, 0);
        cyc(1);
        rst = 1'b0;
        cyc(2);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].reset_first) do_reset();
            slow_ready = tbl[i].slow_ready;
            shift_row(tbl[i]);
            haddr = tbl[i].addr;
            acc0  = acc_cnt;
            done0 = done_cnt;
            push_row();
            latch_pulse();
            if (tbl[i].relatch_gap != 0) begin
                cyc(tbl[i].relatch_gap);
                haddr = 4'h5;
                latch_pulse();
            end
            wait_drain($sformatf("row%0d_drain", i));
            row_checks($sformatf("row%0d", i), acc0, done0, tbl[i].exp_ovf, tbl[i].exp_len);
        end
        slow_ready = 1'b0;

        // 32nd CLK rise and LATCH rise presented together.
        do_reset();
        for (int i = 0; i < 31; i++) hub_bit({1'b0, i[0], 1'b0, 1'b0, 1'b0, i[1]});
        {b1, g1, r1, b0, g0, r0} = 6'b001_001;
        hclk = 1'b0;
        cyc(2);
        for (int ch = 0; ch < 6; ch++) m_sr[ch] = {(ch == 0 || ch == 3), m_sr[ch][31:1]};
        haddr = 4'h2;
        acc0  = acc_cnt;
        done0 = done_cnt;
        push_row();
        hclk = 1'b1;
        hlat = 1'b1;
        cyc(2);
        hclk = 1'b0;
        hlat = 1'b0;
        cyc(2);
        wait_drain("simul_drain");
        row_checks("simul", acc0, done0, 0, 0);

`ifdef HUB75_CAPTURE_STATS_EN
        // Rows 0..F then row 0, four latches each; only the first row 0
        // after row F closes a frame.
        do_reset();
        for (int r = 0; r < 17; r++) begin
            haddr = 4'(r);
            for (int k = 0; k < 4; k++) begin
                push_row();
                latch_pulse();
                wait_drain("stats_drain");
            end
        end
        chk("latch_cnt", 32'(latch_cnt), 68);
        chk("frame_cnt", 32'(frame_cnt), 1);
`endif

        // Reset in the middle of a drain aborts it on the next cycle.
        haddr = 4'h1;
        push_row();
        latch_pulse();
        cyc(20);
        chk("mid_valid_before", pif.PIX_VALID, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid",    pif.PIX_VALID, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_len_err",  len_err, 0);
`ifdef HUB75_CAPTURE_STATS_EN
        chk("mid_rst_latch_cnt", 32'(latch_cnt), 0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
`endif
        cyc(1);
        rst = 1'b0;
        exp_q.delete();
        cyc(10);
        chk("post_rst_valid", pif.PIX_VALID, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
